// File: rtl/can_bit_stuffer.sv
// rtl/can_bit_stuffer.sv - CAN transmit-side bit stuffer
// Inserts one complementary bit after STUFF_LEN identical line bits while stuff_en is high.
module can_bit_stuffer #(
  parameter int unsigned STUFF_LEN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_tick,
  input  logic       tx_bit,
  input  logic       stuff_en,
  output logic       tx,
  output logic       bit_taken,
  output logic       stuff_flag,
  output logic [3:0] run_cnt
);

  typedef enum logic [1:0] {PASS, STUFF_RUN, INSERT} state_t;

  localparam logic [3:0] LEN = 4'(STUFF_LEN);

  state_t     state, state_next;
  logic       last_bit, last_next;
  logic       tx_next, taken_next, stuff_next;
  logic [3:0] cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PASS;
      tx         <= 1'b1;
      last_bit   <= 1'b1;
      run_cnt    <= 4'd0;
      bit_taken  <= 1'b0;
      stuff_flag <= 1'b0;
    end else begin
      state      <= state_next;
      tx         <= tx_next;
      last_bit   <= last_next;
      run_cnt    <= cnt_next;
      bit_taken  <= taken_next;
      stuff_flag <= stuff_next;
    end
  end

  // A stuff bit already owed when stuff_en drops is still sent before PASS.
  always_comb begin
    state_next = state;
    if (bit_tick) begin
      case (state)
        PASS:      if (stuff_en) state_next = STUFF_RUN;
        STUFF_RUN: begin
          if (!stuff_en)             state_next = PASS;
          else if (cnt_next == LEN)  state_next = INSERT;
        end
        INSERT:    state_next = stuff_en ? STUFF_RUN : PASS;
        default:   state_next = PASS;
      endcase
    end
  end

  always_comb begin
    tx_next    = tx;
    last_next  = last_bit;
    cnt_next   = run_cnt;
    taken_next = 1'b0;
    stuff_next = 1'b0;
    if (bit_tick) begin
      case (state)
        STUFF_RUN: begin
          tx_next    = tx_bit;
          last_next  = tx_bit;
          taken_next = 1'b1;
          if (!stuff_en)
            cnt_next = 4'd0;
          else if (tx_bit != last_bit)
            cnt_next = 4'd1;
          else if (run_cnt < LEN)
            cnt_next = run_cnt + 4'd1;
          else
            cnt_next = LEN;
        end
        INSERT: begin
          tx_next    = ~last_bit;
          last_next  = ~last_bit;
          stuff_next = 1'b1;
          cnt_next   = 4'd1;
        end
        default: begin
          tx_next    = tx_bit;
          last_next  = tx_bit;
          taken_next = 1'b1;
          cnt_next   = stuff_en ? 4'd1 : 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_bit_stuffer.sv
// tb/tb_can_bit_stuffer.sv - directed self-checking bench for can_bit_stuffer
module tb_can_bit_stuffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_tick = 1'b0;
  logic       tx_bit = 1'b0;
  logic       stuff_en = 1'b0;
  logic       tx;
  logic       bit_taken;
  logic       stuff_flag;
  logic [3:0] run_cnt;

  int checks = 0;
  int failures = 0;

  can_bit_stuffer #(.STUFF_LEN(5)) dut (
    .clk(clk), .reset(reset), .bit_tick(bit_tick), .tx_bit(tx_bit),
    .stuff_en(stuff_en), .tx(tx), .bit_taken(bit_taken),
    .stuff_flag(stuff_flag), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic e_tx, input logic e_taken,
                            input logic e_stuff, input logic [3:0] e_cnt);
    chk({tag, ".tx"}, {3'b0, tx}, {3'b0, e_tx});
    chk({tag, ".bit_taken"}, {3'b0, bit_taken}, {3'b0, e_taken});
    chk({tag, ".stuff_flag"}, {3'b0, stuff_flag}, {3'b0, e_stuff});
    chk({tag, ".run_cnt"}, run_cnt, e_cnt);
  endtask

  // One bit_tick; back-to-back calls give ticks on consecutive cycles.
  task automatic tick(input string tag, input logic b, input logic en, input logic e_tx,
                      input logic e_taken, input logic e_stuff, input logic [3:0] e_cnt);
    @(negedge clk);
    bit_tick = 1'b1;
    tx_bit   = b;
    stuff_en = en;
    @(posedge clk);
    #1;
    bit_tick = 1'b0;
    expect_out(tag, e_tx, e_taken, e_stuff, e_cnt);
  endtask

  task automatic idle(input string tag, input logic e_tx, input logic [3:0] e_cnt);
    @(negedge clk);
    bit_tick = 1'b0;
    tx_bit   = ~tx_bit;
    @(posedge clk);
    #1;
    expect_out(tag, e_tx, 1'b0, 1'b0, e_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    bit_tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_out("reset", 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    // pass-through, no stuffing
    for (int i = 0; i < 10; i++) tick("pass0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    idle("pass_idle", 1'b0, 4'd0);

    // five 0s then stuff 1
    for (int i = 0; i < 5; i++) tick("run0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'(i + 1));
    tick("stuff1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1);
    idle("stuff1_idle", 1'b1, 4'd1);

    // five 1s, stuff 0, then data 0 extends the stuff run
    do_reset();
    for (int i = 0; i < 5; i++) tick("run1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'(i + 1));
    idle("insert_wait", 1'b1, 4'd5);
    tick("stuff0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    tick("extend", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);

    // 0x5, stuff 1, four data 1s, stuff 0
    do_reset();
    for (int i = 0; i < 5; i++) tick("dbl_run0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'(i + 1));
    tick("dbl_stuff1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1);
    for (int i = 0; i < 4; i++) tick("dbl_run1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'(i + 2));
    tick("dbl_stuff0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    tick("dbl_after", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);

    // reset wins over the tick that would insert
    do_reset();
    for (int i = 0; i < 5; i++) tick("rst_run0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'(i + 1));
    @(negedge clk);
    reset    = 1'b1;
    bit_tick = 1'b1;
    @(posedge clk);
    #1;
    expect_out("rst_insert", 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    reset    = 1'b0;
    bit_tick = 1'b0;
    tick("rst_resume", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);

    // alternating data every cycle
    for (int i = 0; i < 8; i++) tick("alt", 1'(~i[0]), 1'b1, 1'(~i[0]), 1'b1, 1'b0, 4'd1);

    // stuff_en drop mid-run goes straight to pass
    tick("drop_run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    // stuff_en drop with insertion pending: stuff bit still sent first
    do_reset();
    for (int i = 0; i < 5; i++) tick("drop_run0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'(i + 1));
    tick("drop_stuff", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
    tick("drop_pass", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick("drop_pass2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_bit_stuffer.md
CAN_BIT_STUFFER -- requirements
Module: can_bit_stuffer

Interface
REQ-001 Parameter STUFF_LEN, default 5, SHALL set the run length of identical bits after which one stuff bit is inserted; legal range 2..15.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 bit_tick  input  1  one-cycle pulse marking the start of each nominal CAN bit time on the transmit side.
REQ-005 tx_bit  input  1  next unstuffed frame bit from the frame builder; must be stable while bit_tick is high.
REQ-006 stuff_en  input  1  high = stuffing active (SOF through CRC); low = bits pass through unstuffed.
REQ-007 tx  output  1  registered line bit driven to the transceiver; 1 = recessive, 0 = dominant.
REQ-008 bit_taken  output  1  one-cycle pulse: tx_bit was consumed, upstream SHALL present the next bit before the next bit_tick.
REQ-009 stuff_flag  output  1  one-cycle pulse: the bit just placed on tx is a stuff bit.
REQ-010 run_cnt  output  4  current count of consecutive identical bits on tx, including stuff bits.

Function
REQ-011 Internal state: last_bit (1 bit), run counter (4 bits), state register with states PASS, STUFF_RUN, INSERT.
REQ-012 Nothing SHALL change on a cycle without bit_tick, except that bit_taken and stuff_flag SHALL return to 0.
REQ-013 PASS (stuff_en low): on bit_tick -> tx <= tx_bit, bit_taken pulses next cycle, run counter held at 0, last_bit <= tx_bit.
REQ-014 PASS -> STUFF_RUN on the first bit_tick with stuff_en high; that bit SHALL be sent as data with run counter <= 1, whatever the previous line value was.
REQ-015 STUFF_RUN, on bit_tick with run counter < STUFF_LEN -> tx <= tx_bit, bit_taken pulses; run counter <= counter+1 if tx_bit == last_bit, otherwise 1; last_bit <= tx_bit.
REQ-016 STUFF_RUN, when run counter reaches STUFF_LEN -> state INSERT; the insertion SHALL happen at the next bit_tick, never mid-bit.
REQ-017 INSERT, on bit_tick -> tx <= ~last_bit, stuff_flag pulses, bit_taken SHALL NOT pulse (tx_bit is not consumed), run counter <= 1, last_bit <= ~last_bit, state -> STUFF_RUN.
REQ-018 The stuff bit SHALL count as the first bit of a new run; a data bit equal to the stuff bit extends that run.
REQ-019 Output latency: tx, bit_taken and stuff_flag SHALL change on the clock edge at which bit_tick is sampled high; bit_taken/stuff_flag are high for exactly that following cycle.
REQ-020 bit_taken and stuff_flag SHALL never be high in the same cycle.
REQ-021 stuff_en falling while in STUFF_RUN or INSERT SHALL take effect at the next bit_tick: go to PASS, send tx_bit as data, clear the run counter, and drop any pending insertion. The one exception is a pending insertion at counter == STUFF_LEN: the stuff bit for the last stuffed field SHALL still be sent first, then PASS.
REQ-022 The run counter SHALL saturate at STUFF_LEN and never wrap.
REQ-023 bit_tick asserted on consecutive cycles SHALL be handled as consecutive bits, with no lost or duplicated bits.

Reset
REQ-024 With reset high on a rising edge: tx = 1, bit_taken = 0, stuff_flag = 0, run_cnt = 0, last_bit = 1, state = PASS.
REQ-025 reset SHALL take priority over bit_tick in the same cycle.
REQ-026 reset mid-frame (including in INSERT) SHALL abandon the pending stuff bit and return to the values in REQ-024.

Verification
REQ-027 stuff_en=1, tx_bit=0 for 6 bit_ticks -> tx sequence 0,0,0,0,0,1; stuff_flag only on the 6th; bit_taken on the first 5 only.
REQ-028 Data 1,1,1,1,1,0 with stuffing -> tx 1,1,1,1,1,0(stuff),0; the next data 0 extends the run, run_cnt = 2.
REQ-029 Data 0,0,0,0,0,1,1,1,1 -> stuff bit 1 inserted after the 5th bit; run of 1s reaches 5 after the 4th data 1 (stuff + 4), so a second stuff bit 0 follows.
REQ-030 stuff_en=0, tx_bit=0 for 10 bit_ticks -> no stuff_flag, 10 bit_taken pulses, run_cnt = 0 throughout.
REQ-031 reset asserted in the cycle before the bit_tick that would insert a stuff bit -> tx = 1, no stuff_flag, run_cnt = 0.
REQ-032 bit_tick every cycle with alternating data 0,1,0,1... -> tx follows the data, run_cnt stays 1, no stuff_flag.
